// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - shared types and edge numbering for the complete-graph fluidic crossbar
package crossbar_pkg;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_BAD_ROUTE = 2'd1,
    ST_ABORTED   = 2'd2
  } route_status_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    FLOW  = 3'd2,
    CLOSE = 3'd3,
    RESP  = 3'd4
  } route_state_e;

  function automatic int unsigned edge_count(input int unsigned n);
    return n * (n - 1) / 2;
  endfunction

  // Edges are numbered row-major over the upper triangle: (0,1),(0,2)..(0,n-1),(1,2)..
  function automatic int unsigned edge_index(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
    return a * n - a * (a + 1) / 2 + (b - a - 1);
  endfunction

endpackage

// File: rtl/route_edge_decode.sv
// rtl/route_edge_decode.sv - maps an unordered port pair to its crossbar edge index
module route_edge_decode
  import crossbar_pkg::*;
#(
  parameter int N  = 32,
  parameter int PW = 5,
  parameter int IW = 9
) (
  input  logic [PW-1:0] src,
  input  logic [PW-1:0] dst,
  output logic          bad,
  output logic [IW-1:0] idx
);

  localparam int unsigned N_U = N;

  logic [PW-1:0] lo;
  logic [PW-1:0] hi;

  always_comb begin
    lo  = (src < dst) ? src : dst;
    hi  = (src < dst) ? dst : src;
    bad = (src == dst) || (32'(src) >= N_U) || (32'(dst) >= N_U);
    // Bad pairs would underflow the index formula, so they report edge 0.
    idx = bad ? '0 : IW'(edge_index(32'(lo), 32'(hi), N_U));
  end

endmodule

// File: rtl/complete_route_ctrl.sv
// rtl/complete_route_ctrl.sv - one-at-a-time route sequencer driving the crossbar valve plane
module complete_route_ctrl
  import crossbar_pkg::*;
#(
  parameter int N      = 32,
  parameter int PW     = 5,
  parameter int DW     = 16,
  parameter int SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [PW-1:0]          req_src,
  input  logic [PW-1:0]          req_dst,
  input  logic [DW-1:0]          req_dur,
  input  logic                   abort,
  output logic [N*(N-1)/2-1:0]   valve_en,
  output logic                   busy,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_status
);

  localparam int E  = N * (N - 1) / 2;
  localparam int IW = (E > 1) ? $clog2(E) : 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam int CW = (DW > SW) ? DW : SW;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

  route_state_e  state;
  route_state_e  next_state;
  route_status_e status_q;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dur_q;
  logic          out_of_reset;
  logic          accept;
  logic          cnt_zero;
  logic          dec_bad;
  logic [IW-1:0] dec_idx;
  logic [E-1:0]  onehot;

  route_edge_decode #(
    .N  (N),
    .PW (PW),
    .IW (IW)
  ) u_decode (
    .src (req_src),
    .dst (req_dst),
    .bad (dec_bad),
    .idx (dec_idx)
  );

  assign onehot     = {{(E-1){1'b0}}, 1'b1} << dec_idx;
  assign req_ready  = out_of_reset && (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign busy       = (state != IDLE);
  assign cnt_zero   = (cnt == '0);
  assign rsp_status = status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_of_reset <= 1'b0;
    end else begin
      state        <= next_state;
      out_of_reset <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = dec_bad ? RESP : OPEN;
      end
      OPEN: begin
        if (abort)         next_state = CLOSE;
        else if (cnt_zero) next_state = (dur_q == '0) ? CLOSE : FLOW;
      end
      FLOW: begin
        if (abort || cnt_zero) next_state = CLOSE;
      end
      CLOSE: begin
        if (cnt_zero) next_state = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One counter serves all timed phases; it is reloaded on every phase change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dur_q <= '0;
    end else begin
      if (accept) dur_q <= req_dur;
      case (state)
        IDLE: begin
          if (accept) cnt <= SETTLE_LD;
        end
        OPEN: begin
          if (next_state == FLOW)       cnt <= CW'(dur_q) - CW'(1);
          else if (next_state == CLOSE) cnt <= SETTLE_LD;
          else                          cnt <= cnt - CW'(1);
        end
        FLOW: begin
          if (next_state == CLOSE) cnt <= SETTLE_LD;
          else                     cnt <= cnt - CW'(1);
        end
        CLOSE: begin
          if (!cnt_zero) cnt <= cnt - CW'(1);
        end
        default: cnt <= cnt;
      endcase
    end
  end

  // The valve is open exactly while the route sits in OPEN or FLOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valve_en <= '0;
    end else if (accept && !dec_bad) begin
      valve_en <= onehot;
    end else if (next_state != OPEN && next_state != FLOW) begin
      valve_en <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= ST_OK;
    end else if (accept) begin
      status_q <= dec_bad ? ST_BAD_ROUTE : ST_OK;
    end else if ((state == OPEN || state == FLOW) && abort) begin
      status_q <= ST_ABORTED;
    end
  end

  // A rejected route spends its first RESP cycle settling status before presenting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
    end else if (state == RESP && rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end else if (next_state == RESP && state != IDLE) begin
      rsp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_complete_route_ctrl.sv
// tb/tb_complete_route_ctrl.sv - directed self-checking bench for complete_route_ctrl
module tb_complete_route_ctrl;

  localparam int N      = 32;
  localparam int PW     = 5;
  localparam int DW     = 16;
  localparam int SETTLE = 4;
  localparam int E      = N * (N - 1) / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [PW-1:0] req_src = '0;
  logic [PW-1:0] req_dst = '0;
  logic [DW-1:0] req_dur = '0;
  logic          abort = 1'b0;
  logic [E-1:0]  valve_en;
  logic          busy;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_status;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  complete_route_ctrl #(
    .N      (N),
    .PW     (PW),
    .DW     (DW),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_dur    (req_dur),
    .abort      (abort),
    .valve_en   (valve_en),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_route(input string name, input int src, input int dst, input int dur,
                           input int exp_idx, input int on_last, input int abort_cyc,
                           input int rsp_cyc, input int exp_status, input int hold);
    int waited;
    waited = 0;
    while (!req_ready && waited < 50) begin
      step();
      waited++;
    end
    check({name, " ready_before"}, 64'(req_ready), 64'(1));
    req_src   = PW'(src);
    req_dst   = PW'(dst);
    req_dur   = DW'(dur);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= rsp_cyc; c++) begin
      abort = (c == abort_cyc);
      if (exp_idx >= 0)
        check($sformatf("%s c%0d valve_bit", name, c), 64'(valve_en[exp_idx]), 64'(c <= on_last));
      check($sformatf("%s c%0d popcount", name, c), 64'($countones(valve_en)),
            64'((c <= on_last) ? 1 : 0));
      check($sformatf("%s c%0d rsp_valid", name, c), 64'(rsp_valid), 64'(c == rsp_cyc));
      check($sformatf("%s c%0d req_ready", name, c), 64'(req_ready), 64'(0));
      check($sformatf("%s c%0d busy", name, c), 64'(busy), 64'(1));
      if (c < rsp_cyc) step();
    end
    abort = 1'b0;
    check({name, " status"}, 64'(rsp_status), 64'(exp_status));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_src   = PW'(1);
      req_dst   = PW'(2);
      req_dur   = '0;
      step();
      check($sformatf("%s hold%0d rsp_valid", name, h), 64'(rsp_valid), 64'(1));
      check($sformatf("%s hold%0d status", name, h), 64'(rsp_status), 64'(exp_status));
      check($sformatf("%s hold%0d req_ready", name, h), 64'(req_ready), 64'(0));
      check($sformatf("%s hold%0d popcount", name, h), 64'($countones(valve_en)), 64'(0));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({name, " rsp_drop"}, 64'(rsp_valid), 64'(0));
    check({name, " idle_busy"}, 64'(busy), 64'(0));
    check({name, " ready_after"}, 64'(req_ready), 64'(1));
  endtask

  initial begin
    #1;
    check("reset valve", 64'($countones(valve_en)), 64'(0));
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset rsp_status", 64'(rsp_status), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset req_ready", 64'(req_ready), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("release req_ready", 64'(req_ready), 64'(1));

    run_route("r0_1",   0,  1,  10,  0, 14, 0, 19, 0, 1);
    run_route("r5_2",   5,  2,   0, 63,  4, 0,  9, 0, 1);
    run_route("r30_31", 30, 31,  3, 495, 7, 9, 12, 0, 1);
    run_route("r7_7",   7,  7,   0, -1,  0, 0,  2, 1, 5);
    run_route("r3_9",   3,  9, 100, 95,  8, 8, 13, 2, 2);
    run_route("r31_0",  31, 0,   1, 30,  5, 0, 10, 0, 0);

    req_src   = PW'(0);
    req_dst   = PW'(1);
    req_dur   = DW'(10);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("midroute valve_on", 64'(valve_en[0]), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midroute reset valve", 64'($countones(valve_en)), 64'(0));
    check("midroute reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("midroute reset busy", 64'(busy), 64'(0));
    check("midroute reset req_ready", 64'(req_ready), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("post reset req_ready", 64'(req_ready), 64'(1));
    check("post reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("post reset busy", 64'(busy), 64'(0));
    check("post reset valve", 64'($countones(valve_en)), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
